// File: rtl/ps2_scancode_rx_if.sv
// Decoded-key stream from the PS/2 receiver to game logic (valid/ready, head entry presented).
interface ps2_scancode_rx_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_break;
  logic       out_ext;

  modport master (output out_valid, out_code, out_break, out_ext, input out_ready);
  modport slave  (input out_valid, out_code, out_break, out_ext, output out_ready);
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: clock conditioning, 11-bit frame deserialiser with parity/stop/timeout
// checks, E0/F0 prefix folding and a fall-through FIFO of decoded keys.
module ps2_scancode_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_W          = 3
) (
  input  logic                 Clock,
  input  logic                 reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_dat,
  ps2_scancode_rx_if.master    out_if,
  output logic [CNT_W-1:0]     fifo_count,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int unsigned FILT_W = 8;
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W  = 10;

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} state_t;

  logic [1:0]        clk_sync_q, clk_sync_d;
  logic [1:0]        dat_sync_q, dat_sync_d;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;

  logic              fall_c, dat_c, to_hit_c, push_c, pop_c, full_c, wr_en_c;
  logic [ENT_W-1:0]  head_c;

  // Synchronisers and glitch filter; fall_c marks the cycle the filtered clock drops.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else                                        filt_cnt_d = filt_cnt_q + FILT_W'(1);
    end
    fall_c = filt_q & ~filt_d;
    dat_c  = dat_sync_q[1];
  end

  // Frame FSM next-state, timeout and prefix tracking.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    push_c       = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    to_hit_c     = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    if (fall_c || state_q == IDLE || state_q == DECODE) to_cnt_d = '0;
    else                                                 to_cnt_d = to_cnt_q + TO_W'(1);

    case (state_q)
      IDLE: begin
        if (fall_c && !dat_c) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (fall_c) begin
          shift_d[bit_cnt_q] = dat_c;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end else if (to_hit_c) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      PARITY: begin
        if (fall_c) begin
          par_d   = dat_c;
          state_d = STOP;
        end else if (to_hit_c) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      STOP: begin
        if (fall_c) begin
          if (!dat_c) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (^{shift_q, par_q} == 1'b0) begin
            parity_err_d = 1'b1;
            ext_d        = 1'b0;
            brk_d        = 1'b0;
            state_d      = IDLE;
          end else begin
            state_d = DECODE;
          end
        end else if (to_hit_c) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (shift_q == 8'hE0)      ext_d = 1'b1;
        else if (shift_q == 8'hF0) brk_d = 1'b1;
        else begin
          push_c = 1'b1;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head pops in the same cycle.
  always_comb begin
    full_c     = (count_q == CNT_W'(FIFO_DEPTH));
    pop_c      = (count_q != '0) & out_if.out_ready;
    wr_en_c    = push_c & (~full_c | pop_c);
    overflow_d = push_c & full_c & ~pop_c;
    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q;
    if (wr_en_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!wr_en_c && pop_c) count_d = count_q - CNT_W'(1);
    mem_d = mem_q;
    if (wr_en_c) mem_d[wr_ptr_q] = {ext_q, brk_q, shift_q};
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  // Head entry shown only while valid so an empty FIFO presents all zeros.
  assign head_c           = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_code  = head_c[7:0];
  assign out_if.out_break = head_c[8];
  assign out_if.out_ext   = head_c[9];
  assign fifo_count       = count_q;
  assign parity_err       = parity_err_q;
  assign frame_err        = frame_err_q;
  assign overflow         = overflow_q;

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Parametrised PS/2 keyboard receiver, successor to the single-byte PS/2 controller.
- Synchronises and deglitches the PS/2 clock.
- Deserialises 11-bit frames and checks odd parity and the stop bit.
- Recovers from stalled frames using a timeout.
- Folds E0/F0 prefixes into make/break/extended flags.
- Buffers decoded keys in a FIFO with a valid/ready interface to game logic.

Parameters:
- FILTER_LEN, 8: consecutive identical Clock samples required before the filtered PS/2 clock changes (range 2..255).
- TIMEOUT_CYCLES, 50000: Clock cycles without a filtered falling edge before a partial frame is aborted (1 ms at 50 MHz).
- FIFO_DEPTH, 4: decoded-key FIFO entries; power of two, ≥2.
- CNT_W, 3: width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- Clock, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-low.
- ps2_clk, input, 1: raw PS/2 clock pin, asynchronous to Clock.
- ps2_dat, input, 1: raw PS/2 data pin, asynchronous to Clock.
- out_valid, output, 1: FIFO non-empty; head entry presented.
- out_ready, input, 1: consumer accepts the head entry when high with out_valid.
- out_code, output, 8: head scancode, excluding prefixes.
- out_break, output, 1: head entry was preceded by F0 (key release).
- out_ext, output, 1: head entry was preceded by E0 (extended key).
- fifo_count, output, CNT_W: number of occupied entries.
- parity_err, output, 1: one-cycle pulse when a frame fails odd parity.
- frame_err, output, 1: one-cycle pulse on a bad stop bit or a timeout.
- overflow, output, 1: one-cycle pulse when a decoded key is dropped because the FIFO is full.

Behaviour:
- Reset (reset==0 at posedge) applies to all registers regardless of frame state:
  - state=IDLE; FIFO emptied; prefix flags cleared; filter and timeout counters cleared.
  - All outputs 0: out_valid, out_code, out_break, out_ext, fifo_count, parity_err, frame_err, overflow.
  - The filtered clock resets to 1.
  - A reset mid-frame discards the partial frame with no error pulse.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - Filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples. Shorter glitches are ignored.
  - fall = filtered clock 1→0 this cycle. Data is sampled (synchronised ps2_dat) only on fall.
- Frame FSM, 11-bit frame: start, D0..D7 LSB first, parity, stop.
  - IDLE: on fall with data=0 → DATA, bit count=0. On fall with data=1 → stay IDLE, no error.
  - DATA: on each fall, shift bit into shift[bit count] and increment; after the 8th bit → PARITY.
  - PARITY: on fall, capture parity bit → STOP.
  - STOP: on fall:
    - data=0 → frame_err pulse, → IDLE, byte discarded.
    - data=1 and XOR(D0..D7,parity)==0 → parity_err pulse, clear both prefix flags, → IDLE.
    - otherwise → DECODE.
  - DECODE (1 cycle, → IDLE):
    - byte 0xE0 sets ext flag; byte 0xF0 sets brk flag; neither is pushed.
    - Any other byte is pushed as {ext,brk,byte}, then both flags clear.
- Timeout:
  - Counter clears on every fall and in IDLE.
  - In DATA/PARITY/STOP, reaching TIMEOUT_CYCLES → frame_err pulse, → IDLE; prefix flags retained.
- FIFO:
  - First-word fall-through: out_* reflect the head entry whenever out_valid=1.
  - out_valid = (fifo_count != 0). Pop = out_valid & out_ready.
  - Push while not full: accepted. Push while full with no pop: dropped, overflow pulse, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur, fifo_count unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push is accepted and no pop occurs (out_valid was 0).
  - out_ready while empty: no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: the push occurs in the DECODE cycle, one cycle after the stop-bit fall. out_valid rises two Clock cycles after the stop-bit fall when the FIFO was empty.
- Error pulses are mutually exclusive per frame and last exactly 1 Clock cycle.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1), out_ready=0 → out_valid=1, out_code=0x1C, out_break=0, out_ext=0, fifo_count=1, no error pulses.
- Frames E0, F0, 75, then 29 → entry0 {0x75, brk=1, ext=1}, entry1 {0x29, brk=0, ext=0}; fifo_count=2.
- Frame 0x1C with parity bit 1 → parity_err pulses once, fifo_count stays 0. Following F0 then bad-parity 0x1C, then a valid 0x1C → break=0 (prefix cleared by the error).
- Stop at TIMEOUT_CYCLES after D3 → frame_err pulses once at timeout, state IDLE. Next valid frame 0x23 → out_code=0x23.
- FIFO_DEPTH=4, out_ready=0, five codes 0x01..0x05 → fifo_count=4, overflow pulses on the 5th. Drain gives 0x01..0x04.
- Glitch: ps2_clk low for FILTER_LEN-2 cycles while idle → no state change. Reset asserted during DATA → all outputs 0, next full frame decodes correctly.
